// File: rtl/if_fetch.sv
// Instruction-fetch stage: direct-mapped one-word-per-line instruction cache
// in front of a byte-serial memory controller. Hits are presented to the
// IF/ID latch one cycle after lookup. A miss fetches the word from memory one
// byte at a time, fills the line, and then looks it up again.
module if_fetch #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  jmp_status_i,
    input  logic                  flush_i,
    input  logic                  if_stall_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic                  mem_data_valid_i,
    input  logic [7:0]            mem_data_i,
    output logic                  stallreq_o,
    output logic                  if_valid_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [31:0]           if_inst_o,
    output logic                  if_jmp_status_o
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           buf_q, buf_d;       // first three bytes; the fourth goes straight into the line
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  mem_req_q, mem_req_d;
    logic                  if_valid_q, if_valid_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]           if_inst_q, if_inst_d;
    logic                  if_jmp_q, if_jmp_d;

    // Cache storage: only the valid bits need a reset value.
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [31:0]           data_q [LINES];

    logic [INDEX_BITS-1:0] lookup_idx_s;
    logic [TAG_BITS-1:0]   lookup_tag_s;
    logic                  hit_s;
    logic [INDEX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0]   fill_tag_s;
    logic                  fill_we_s;
    logic [31:0]           fill_data_s;

    assign lookup_idx_s = pc_i[INDEX_BITS+1:2];
    assign lookup_tag_s = pc_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit_s        = valid_q[lookup_idx_s] && (tag_q[lookup_idx_s] == lookup_tag_s);
    assign fill_idx_s   = miss_addr_q[INDEX_BITS+1:2];
    assign fill_tag_s   = miss_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

    // The PC must wait whenever no instruction can be produced this cycle.
    assign stallreq_o      = (state_q != S_IDLE) || !hit_s;
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = miss_addr_q;
    assign if_valid_o      = if_valid_q;
    assign if_pc_o         = if_pc_q;
    assign if_inst_o       = if_inst_q;
    assign if_jmp_status_o = if_jmp_q;

    // Next-state, memory handshake, line fill and output-register updates.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        miss_addr_d = miss_addr_q;
        mem_req_d   = mem_req_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if_jmp_d    = if_jmp_q;
        fill_we_s   = 1'b0;
        fill_data_s = {mem_data_i, buf_q};

        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    if_valid_d = 1'b0;
                end else if (hit_s) begin
                    if (!if_stall_i) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_i;
                        if_inst_d  = data_q[lookup_idx_s];
                        if_jmp_d   = jmp_status_i;
                    end else begin
                        if_valid_d = if_valid_q;
                    end
                end else begin
                    miss_addr_d = {pc_i[ADDR_WIDTH-1:2], 2'b00};
                    state_d     = S_REQ;
                    mem_req_d   = 1'b1;
                    if (!if_stall_i) begin
                        if_valid_d = 1'b0;
                    end else begin
                        if_valid_d = if_valid_q;
                    end
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    // Request is withdrawn before acceptance; nothing comes back.
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b0;
                end else if (mem_ack_i) begin
                    state_d    = S_RECV;
                    byte_cnt_d = 2'd0;
                    mem_req_d  = 1'b0;
                end else begin
                    mem_req_d  = 1'b1;
                end
            end
            S_RECV: begin
                // An accepted transfer cannot be aborted; a flush only kills the outputs.
                if (flush_i) begin
                    if_valid_d = 1'b0;
                end else begin
                    if_valid_d = if_valid_q;
                end
                if (mem_data_valid_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    buf_d[7:0]   = mem_data_i;
                        2'd1:    buf_d[15:8]  = mem_data_i;
                        2'd2:    buf_d[23:16] = mem_data_i;
                        default: begin
                            fill_we_s = 1'b1;
                            state_d   = S_IDLE;
                        end
                    endcase
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            buf_q       <= 24'd0;
            miss_addr_q <= '0;
            mem_req_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= 32'd0;
            if_jmp_q    <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            buf_q       <= buf_d;
            miss_addr_q <= miss_addr_d;
            mem_req_q   <= mem_req_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_jmp_q    <= if_jmp_d;
        end
    end

    // Line valid bits: cleared by reset, set by a completed fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (rdy && fill_we_s) begin
            valid_q[fill_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays: a fill overwrites whatever the line held.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we_s) begin
            tag_q[fill_idx_s]  <= fill_tag_s;
            data_q[fill_idx_s] <= fill_data_s;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the stimulus process pushes the expected
// presentations into a queue, and a monitor pops and compares one entry each
// time the stage presents a new instruction.
module tb_if_fetch;
    localparam logic [31:0] INST0 = 32'h0010_0013;
    localparam logic [31:0] W_BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] W_40  = 32'h1234_5678;
    localparam logic [31:0] W_100 = 32'hCAFE_F00D;
    localparam logic [31:0] W_104 = 32'hA5A5_5A5A;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_i;
    logic        jmp_status_i;
    logic        flush_i;
    logic        if_stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic        mem_data_valid_i;
    logic [7:0]  mem_data_i;
    logic        stallreq_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_jmp_status_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jmp;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_cnt;

    if_fetch #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .jmp_status_i(jmp_status_i),
        .flush_i(flush_i), .if_stall_i(if_stall_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_valid_i(mem_data_valid_i),
        .mem_data_i(mem_data_i), .stallreq_o(stallreq_o), .if_valid_o(if_valid_o),
        .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_jmp_status_o(if_jmp_status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic jmp);
        exp_t e;
        e.pc = pc; e.inst = inst; e.jmp = jmp;
        exp_q.push_back(e);
    endtask

    // Acts as the memory controller: acks immediately, returns one byte per cycle.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word);
        int n = 0;
        while (!mem_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("serve_req_seen", {31'd0, mem_req_o}, 32'd1);
        chk("serve_req_addr", mem_addr_o, exp_addr);
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_data_valid_i = 1'b1;
            mem_data_i       = word[8*b +: 8];
            @(negedge clk);
        end
        mem_data_valid_i = 1'b0;
    endtask

    // Monitor: one scoreboard entry per new presentation on the IF/ID outputs.
    logic        prev_v;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_jmp;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (if_valid_o && (!prev_v || if_pc_o != prev_pc || if_inst_o != prev_inst
                               || if_jmp_status_o != prev_jmp)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc=0x%08h inst=0x%08h jmp=%0d, expected none",
                             if_pc_o, if_inst_o, if_jmp_status_o);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc_o !== e.pc || if_inst_o !== e.inst || if_jmp_status_o !== e.jmp) begin
                        n_fail++;
                        $display("FAIL sb_present: got pc=0x%08h inst=0x%08h jmp=%0d, expected pc=0x%08h inst=0x%08h jmp=%0d",
                                 if_pc_o, if_inst_o, if_jmp_status_o, e.pc, e.inst, e.jmp);
                    end
                end
            end
            prev_v = if_valid_o;
        end
        prev_pc   = if_pc_o;
        prev_inst = if_inst_o;
        prev_jmp  = if_jmp_status_o;
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; pc_i = 32'd0; jmp_status_i = 1'b0; flush_i = 1'b0;
        if_stall_i = 1'b0; mem_ack_i = 1'b0; mem_data_valid_i = 1'b0; mem_data_i = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_if_pc", if_pc_o, 32'd0);
        chk("rst_if_inst", if_inst_o, 32'd0);
        chk("rst_if_jmp", {31'd0, if_jmp_status_o}, 32'd0);

        // Cold miss at 0x0: instruction appears on the 7th edge after release
        push(32'h0, INST0, 1'b0);
        rst = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (stallreq_o) stall_cnt++;
            if (c == 1) begin
                chk("cold_req", {31'd0, mem_req_o}, 32'd1);
                chk("cold_addr", mem_addr_o, 32'h0);
                mem_ack_i = 1'b1;
            end else begin
                mem_ack_i = 1'b0;
            end
            if (c >= 2 && c <= 5) begin
                mem_data_valid_i = 1'b1;
                mem_data_i = INST0[8*(c-2) +: 8];
            end else begin
                mem_data_valid_i = 1'b0;
            end
            if (c == 6) chk("cold_not_yet_valid", {31'd0, if_valid_o}, 32'd0);
            if (c == 7) chk("cold_valid_at_7", {31'd0, if_valid_o}, 32'd1);
            @(negedge clk);
        end
        chk("cold_stall_cycles", stall_cnt, 32'd6);

        // Hit: same pc, jump flag now set, no memory traffic
        chk("hit_stallreq", {31'd0, stallreq_o}, 32'd0);
        push(32'h0, INST0, 1'b1);
        jmp_status_i = 1'b1;
        @(negedge clk);
        chk("hit_no_req", {31'd0, mem_req_o}, 32'd0);

        // Stall: outputs hold on a hit and across a conflict fill of 0x200
        if_stall_i = 1'b1;
        jmp_status_i = 1'b0;
        @(negedge clk);
        chk("stall_hold_jmp", {31'd0, if_jmp_status_o}, 32'd1);
        pc_i = 32'h200;
        serve(32'h200, W_BAD);
        chk("stall_hold_pc", if_pc_o, 32'h0);
        chk("stall_hold_valid", {31'd0, if_valid_o}, 32'd1);
        chk("stall_fill_hit", {31'd0, stallreq_o}, 32'd0);
        push(32'h200, W_BAD, 1'b0);
        if_stall_i = 1'b0;
        repeat (2) @(negedge clk);

        // Conflict: 0x0 was evicted by 0x200
        push(32'h0, INST0, 1'b0);
        pc_i = 32'h0;
        #1;
        chk("conflict_miss", {31'd0, stallreq_o}, 32'd1);
        serve(32'h0, INST0);
        repeat (2) @(negedge clk);

        // Flush in REQ with ack withheld, then a fresh fetch of 0x40
        pc_i = 32'h80;
        @(negedge clk);
        chk("freq_req", {31'd0, mem_req_o}, 32'd1);
        chk("freq_addr", mem_addr_o, 32'h80);
        flush_i = 1'b1;
        @(negedge clk);
        chk("freq_req_dropped", {31'd0, mem_req_o}, 32'd0);
        chk("freq_valid", {31'd0, if_valid_o}, 32'd0);
        flush_i = 1'b0;
        pc_i = 32'h40;
        push(32'h40, W_40, 1'b0);
        serve(32'h40, W_40);
        repeat (2) @(negedge clk);

        // Flush beats a simultaneous hit
        pc_i = 32'h0;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_over_hit", {31'd0, if_valid_o}, 32'd0);
        flush_i = 1'b0;
        push(32'h0, INST0, 1'b0);
        repeat (2) @(negedge clk);

        // Flush in RECV after 2 bytes, held through the final byte
        pc_i = 32'h100;
        @(negedge clk);
        chk("frecv_addr", mem_addr_o, 32'h100);
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_data_valid_i = 1'b1;
            mem_data_i = W_100[8*b +: 8];
            if (b >= 2) flush_i = 1'b1;
            @(negedge clk);
        end
        mem_data_valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("frecv_valid", {31'd0, if_valid_o}, 32'd0);
        chk("frecv_line_hit", {31'd0, stallreq_o}, 32'd0);
        push(32'h100, W_100, 1'b0);
        @(negedge clk);
        chk("frecv_no_refetch", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);

        // rdy low for 3 cycles mid-RECV; bytes offered meanwhile must be ignored
        pc_i = 32'h104;
        @(negedge clk);
        chk("rdy_addr", mem_addr_o, 32'h104);
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_data_valid_i = 1'b1;
            mem_data_i = W_104[8*b +: 8];
            @(negedge clk);
        end
        rdy = 1'b0;
        mem_data_i = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rdy_freeze_stall", {31'd0, stallreq_o}, 32'd1);
            chk("rdy_freeze_valid", {31'd0, if_valid_o}, 32'd0);
        end
        rdy = 1'b1;
        for (int b = 2; b < 4; b++) begin
            mem_data_i = W_104[8*b +: 8];
            @(negedge clk);
        end
        mem_data_valid_i = 1'b0;
        push(32'h104, W_104, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a request
        pc_i = 32'h300;
        @(negedge clk);
        chk("rstmid_req", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req_clr", {31'd0, mem_req_o}, 32'd0);
        chk("rstmid_addr_clr", mem_addr_o, 32'd0);
        chk("rstmid_inst_clr", if_inst_o, 32'd0);
        rst = 1'b0;
        pc_i = 32'h0;
        #1;
        chk("rstmid_lines_invalid", {31'd0, stallreq_o}, 32'd1);
        @(negedge clk);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
